// File: rtl/accel_initiator.sv
// accel_initiator
//   Bus initiator that pushes N 32-bit operands to an accelerator's write
//   window, then reads back the 64-bit product (low word first, then high
//   word). Every bus transaction is followed by a one-cycle gap with
//   mem_valid low.
//
// Ports
//   clk, resetn          : clock, asynchronous active-low reset
//   start                : job request, sampled only in IDLE
//   operands[32*N-1:0]   : operand k in bits [32k+31:32k], latched at start
//   busy                 : job in progress (start acceptance until done)
//   done, error          : one-cycle completion pulse; error=1 on abort
//   result[63:0]         : product read back, updated only at read completion
//   mem_valid/mem_ready  : bus handshake
//   mem_addr/mem_wdata   : bus address / write data
//   mem_wstrb            : byte strobes, 0 for reads
//   mem_rdata            : bus read data
//
// Configuration
//   ACCEL_INITIATOR_TIMEOUT_EN : when defined, a watchdog aborts any bus
//   transaction that has waited TIMEOUT cycles for mem_ready (done with
//   error=1, result unchanged). When undefined the initiator waits forever
//   and error is constant 0.

module accel_initiator #(
    parameter logic [31:0] ADDR_WRITE = 32'h0100_3000,
    parameter logic [31:0] ADDR_READ  = 32'h0100_4000,
    parameter int          N          = 3,
    parameter int          TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [32*N-1:0]   operands,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [63:0]       result,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata
);

    if (N < 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("accel_initiator: N and TIMEOUT must both be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        WR,
        GAP,
        RD_LO,
        RD_HI,
        FIN
    } state_t;

    state_t            state_q, state_d;
    // Phase index: 0..N-1 selects the operand being written, N means the
    // low-word read is next, N+1 the high-word read. GAP uses it to decide
    // where to go, so no separate "return state" register is needed.
    logic [31:0]       k_q, k_d;
    logic [32*N-1:0]   ops_q, ops_d;
    logic [63:0]       res_q, res_d;
    // Set on the first edge after reset release; start is ignored before it.
    logic              armed_q;

`ifdef ACCEL_INITIATOR_TIMEOUT_EN
    logic [31:0]       cnt_q, cnt_d;
    logic              err_q, err_d;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            k_q     <= '0;
            ops_q   <= '0;
            res_q   <= '0;
            armed_q <= 1'b0;
`ifdef ACCEL_INITIATOR_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ops_q   <= ops_d;
            res_q   <= res_d;
            armed_q <= 1'b1;
`ifdef ACCEL_INITIATOR_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Bus outputs are decoded from registered state only, so they stay
    // stable while waiting for mem_ready and drop to zero as soon as the
    // asynchronous reset forces IDLE.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        ops_d     = ops_q;
        res_d     = res_q;
        busy      = 1'b1;
        done      = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
`ifdef ACCEL_INITIATOR_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start && armed_q) begin
                    ops_d   = operands;
                    k_d     = '0;
                    state_d = WR;
`ifdef ACCEL_INITIATOR_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            WR: begin
                mem_valid = 1'b1;
                mem_addr  = ADDR_WRITE + (k_q << 2);
                mem_wdata = ops_q[32*k_q +: 32];
                mem_wstrb = '1;
                if (mem_ready) begin
                    k_d     = k_q + 32'd1;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (k_q < 32'(N)) begin
                    state_d = WR;
                end else if (k_q == 32'(N)) begin
                    state_d = RD_LO;
                end else begin
                    state_d = RD_HI;
                end
            end
            RD_LO: begin
                mem_valid = 1'b1;
                mem_addr  = ADDR_READ;
                if (mem_ready) begin
                    res_d[31:0] = mem_rdata;
                    k_d         = k_q + 32'd1;
                    state_d     = GAP;
                end
            end
            RD_HI: begin
                mem_valid = 1'b1;
                mem_addr  = ADDR_READ + 32'd4;
                if (mem_ready) begin
                    res_d[63:32] = mem_rdata;
                    k_d          = '0;
                    state_d      = FIN;
                end
            end
            FIN: begin
                busy    = 1'b0;
                done    = 1'b1;
                k_d     = '0;
                state_d = IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase

`ifdef ACCEL_INITIATOR_TIMEOUT_EN
        // Counts wait cycles of the current transaction. The abort overrides
        // the case above; no read can complete in the same cycle because
        // mem_ready is low here, so result is left untouched.
        if (mem_valid && !mem_ready) begin
            cnt_d = cnt_q + 32'd1;
            if (cnt_q + 32'd1 >= 32'(TIMEOUT)) begin
                state_d = FIN;
                k_d     = '0;
                err_d   = 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
`endif
    end

`ifdef ACCEL_INITIATOR_TIMEOUT_EN
    assign error = done & err_q;
`else
    assign error = 1'b0;
`endif

    assign result = res_q;

endmodule

// File: tb/tb_accel_initiator.sv
// Self-checking bench for accel_initiator: a responder models the
// accelerator (multiplies the written operands), the stimulus pushes the
// expected bus transactions and job outcomes into queues, and a monitor
// compares them whenever the DUT presents a transaction or a done pulse.
module tb_accel_initiator;

    localparam int          N  = 3;
    localparam logic [31:0] AW = 32'h0100_3000;
    localparam logic [31:0] AR = 32'h0100_4000;
    localparam int          TO = 255;

    logic              clk;
    logic              resetn;
    logic              start;
    logic [32*N-1:0]   operands;
    logic              busy, done, error;
    logic [63:0]       result;
    logic              mem_valid, mem_ready;
    logic [31:0]       mem_addr, mem_wdata, mem_rdata;
    logic [3:0]        mem_wstrb;

    accel_initiator #(
        .ADDR_WRITE (AW),
        .ADDR_READ  (AR),
        .N          (N),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .operands  (operands),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .result    (result),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_t;

    typedef struct {
        logic [63:0] res;
        logic        err;
        int          start_edge;
        int          lat;
    } job_t;

    bus_t exp_bus[$];
    job_t exp_job[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic [63:0] last_res = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mult(input logic [32*N-1:0] ops);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < N; k++) p = p * {32'd0, ops[32*k +: 32]};
        return p;
    endfunction

    // ---------------- responder (accelerator model) ----------------
    // Ready is registered: rises stall_tab[t]+1 cycles into transaction t,
    // and stays high through the following gap cycle.
    int          stall_tab [N+2];
    int          tidx, wc;
    logic        rdy;
    logic [32*N-1:0] wbuf;
    logic [63:0] rprod;

    assign mem_ready = rdy;
    assign rprod     = mult(wbuf);
    assign mem_rdata = (mem_addr == AR + 32'd4) ? rprod[63:32] : rprod[31:0];

    always @(posedge clk) begin
        if (!resetn) begin
            rdy  <= 1'b0;
            wc   <= 0;
            tidx <= 0;
        end else if (mem_valid && mem_ready) begin
            rdy  <= 1'b1;
            wc   <= 0;
            tidx <= (tidx == N + 1) ? 0 : tidx + 1;
            if (mem_wstrb == 4'hF) wbuf[32*((mem_addr - AW) >> 2) +: 32] <= mem_wdata;
        end else if (mem_valid) begin
            if (wc >= stall_tab[tidx]) rdy <= 1'b1;
            else wc <= wc + 1;
        end else begin
            rdy <= 1'b0;
            wc  <= 0;
            if (done) tidx <= 0;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic gap_pend;
        job_t j;
        if (!resetn) begin
            gap_pend = 1'b0;
        end else begin
            if (gap_pend) begin
                chk("gap_valid_low", mem_valid, 0);
                gap_pend = 1'b0;
            end else if (mem_valid) begin
                chk("busy_in_txn", busy, 1);
                if (exp_bus.size() == 0) begin
                    chk("unexpected_txn_addr", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    chk("txn_addr",  mem_addr,  exp_bus[0].addr);
                    chk("txn_wdata", mem_wdata, exp_bus[0].wdata);
                    chk("txn_wstrb", mem_wstrb, exp_bus[0].wstrb);
                    if (mem_ready) begin
                        void'(exp_bus.pop_front());
                        gap_pend = 1'b1;
                    end
                end
            end
            if (done) begin
                if (exp_job.size() == 0) begin
                    chk("unexpected_done", done, 0);
                end else begin
                    j = exp_job.pop_front();
                    chk("result",  result, j.res);
                    chk("error",   error, j.err);
                    chk("latency", cyc - j.start_edge, j.lat);
                    chk("busy_at_done", busy, 0);
                end
            end else begin
                chk("error_without_done", error, 0);
            end
        end
    end

    // ---------------- stimulus / reference model ----------------
    function automatic int job_lat();
        int l;
        l = 3 * (N + 2) - 1;
        for (int t = 0; t < N + 2; t++) l += stall_tab[t];
        return l;
    endfunction

    task automatic push_job(input logic [32*N-1:0] ops, input int sedge, input int lat);
        bus_t b;
        job_t j;
        for (int k = 0; k < N; k++) begin
            b.addr = AW + 32'(4 * k); b.wdata = ops[32*k +: 32]; b.wstrb = 4'hF;
            exp_bus.push_back(b);
        end
        b.addr = AR;         b.wdata = '0; b.wstrb = '0; exp_bus.push_back(b);
        b.addr = AR + 32'd4; b.wdata = '0; b.wstrb = '0; exp_bus.push_back(b);
        j.res = mult(ops); j.err = 1'b0; j.start_edge = sedge; j.lat = lat;
        exp_job.push_back(j);
        last_res = j.res;
    endtask

    task automatic scramble_operands();
        for (int k = 0; k < N; k++) operands[32*k +: 32] = $urandom;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (exp_job.size() != 0 && t < 3000) begin
            @(negedge clk); #1;
            t++;
        end
        chk("job_completed", exp_job.size(), 0);
        exp_job.delete();
        @(negedge clk);
    endtask

    task automatic run_job(input logic [32*N-1:0] ops);
        push_job(ops, cyc + 1, job_lat());
        start = 1'b1;
        operands = ops;
        @(negedge clk);
        start = 1'b0;
        scramble_operands();
        wait_idle();
    endtask

    task automatic clear_stalls();
        for (int t = 0; t < N + 2; t++) stall_tab[t] = 0;
    endtask

    initial begin : stim
        logic [32*N-1:0] a, b;
        int s, l, guard;
        job_t j;
        bus_t bt;

        resetn = 1'b0; start = 1'b0; operands = '0; wbuf = '0;
        clear_stalls();
        repeat (3) @(negedge clk);
        chk("rst_valid",  mem_valid, 0);
        chk("rst_addr",   mem_addr, 0);
        chk("rst_wdata",  mem_wdata, 0);
        chk("rst_wstrb",  mem_wstrb, 0);
        chk("rst_busy",   busy, 0);
        chk("rst_done",   done, 0);
        chk("rst_error",  error, 0);
        chk("rst_result", result, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Basic job: 3*5*7 with one-wait responder.
        run_job({32'd7, 32'd5, 32'd3});
        chk("result_105_held", result, 64'd105);

        // Full-width product, low word then high word.
        run_job({32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF});

        // Long stall on write k=1.
        stall_tab[1] = 10;
        run_job({32'd7, 32'd5, 32'd3});
        clear_stalls();

        // Randomized jobs with random wait states.
        for (int i = 0; i < 20; i++) begin
            for (int t = 0; t < N + 2; t++) stall_tab[t] = $urandom_range(0, 3);
            for (int k = 0; k < N; k++) a[32*k +: 32] = $urandom;
            run_job(a);
        end
        clear_stalls();

        // Start held through a job: next job accepted only in the IDLE cycle
        // after FIN; operand changes mid-job have no effect.
        for (int k = 0; k < N; k++) a[32*k +: 32] = $urandom;
        for (int k = 0; k < N; k++) b[32*k +: 32] = $urandom;
        s = cyc + 1;
        l = job_lat();
        push_job(a, s, l);
        push_job(b, s + l + 2, l);
        start = 1'b1;
        operands = a;
        @(negedge clk);
        operands = b;
        while (cyc < s + l + 2) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset while the low-word read is waiting.
        stall_tab[N] = 4;
        push_job({32'd9, 32'd8, 32'd7}, cyc + 1, job_lat());
        start = 1'b1;
        operands = {32'd9, 32'd8, 32'd7};
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(mem_valid && mem_addr == AR) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("reached_rd_lo", mem_addr, AR);
        #1 resetn = 1'b0;
        #1;
        chk("midrst_valid", mem_valid, 0);
        chk("midrst_addr",  mem_addr, 0);
        chk("midrst_busy",  busy, 0);
        chk("midrst_done",  done, 0);
        chk("midrst_result", result, 0);
        exp_bus.delete();
        exp_job.delete();
        last_res = '0;
        clear_stalls();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        run_job({32'd11, 32'd3, 32'd2});

`ifdef ACCEL_INITIATOR_TIMEOUT_EN
        // Responder never answers the first write: watchdog aborts.
        stall_tab[0] = 1000;
        bt.addr = AW; bt.wdata = 32'd4; bt.wstrb = 4'hF;
        exp_bus.push_back(bt);
        j.res = last_res; j.err = 1'b1; j.start_edge = cyc + 1; j.lat = TO;
        exp_job.push_back(j);
        start = 1'b1;
        operands = {32'd6, 32'd5, 32'd4};
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        chk("timeout_result_kept", result, 64'd66);
`else
        // Without the watchdog a 300-cycle stall just delays the job.
        stall_tab[0] = 300;
        run_job({32'd6, 32'd5, 32'd4});
        chk("long_stall_result", result, 64'd120);
`endif
        clear_stalls();

        repeat (3) @(negedge clk);
        chk("bus_queue_drained", exp_bus.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/accel_initiator.md
ACCEL_INITIATOR -- requirements
Module: accel_initiator

Interface
REQ-001 SHALL have parameter ADDR_WRITE, default 'h1003000: base address of the operand write window, word k at ADDR_WRITE+4*k.
REQ-002 SHALL have parameter ADDR_READ, default 'h1004000: product low word at ADDR_READ, high word at ADDR_READ+4.
REQ-003 SHALL have parameter N, default 3: number of 32-bit operands per job.
REQ-004 SHALL have parameter TIMEOUT, default 255: wait-cycle limit per bus transaction (used only under REQ-024).
REQ-005 Ports, clock and reset first:
 clk  input  1  single clock, all state on rising edge
 resetn  input  1  asynchronous, active-low reset
 start  input  1  job request, sampled only in IDLE
 operands  input  32*N  operand k in bits [32k+31:32k]
 busy  output  1  high from start acceptance until done
 done  output  1  one-cycle completion pulse
 error  output  1  valid with done; 1 = job aborted
 result  output  64  product read back from responder
 mem_valid  output  1  bus request
 mem_ready  input  1  responder acknowledge
 mem_addr  output  32  bus address
 mem_wdata  output  32  write data
 mem_wstrb  output  4  byte strobes; 0 = read
 mem_rdata  input  32  read data

Function
REQ-006 SHALL implement states IDLE, WR, GAP, RD_LO, RD_HI, FIN.
REQ-007 In IDLE with start=1 at an edge, SHALL latch operands, set busy=1, enter WR with index k=0.
REQ-008 SHALL ignore start while busy=1; latched operands SHALL not change mid-job.
REQ-009 In WR: mem_valid=1, mem_addr=ADDR_WRITE+4*k, mem_wdata=operand k, mem_wstrb=4'hF.
REQ-010 In RD_LO/RD_HI: mem_valid=1, mem_addr=ADDR_READ / ADDR_READ+4, mem_wstrb=0, mem_wdata=0.
REQ-011 While mem_valid=1 and mem_ready=0, mem_addr, mem_wdata and mem_wstrb SHALL hold stable.
REQ-012 A transaction completes at the first edge where mem_valid=1 and mem_ready=1; next cycle SHALL be GAP with mem_valid=0.
REQ-013 GAP SHALL last exactly one cycle; mem_ready SHALL be ignored in GAP (responder's registered ready may still be high).
REQ-014 Sequence: WR k=0..N-1, then RD_LO, then RD_HI, each separated by GAP; RD_LO completion SHALL load result[31:0] from mem_rdata, RD_HI completion result[63:32].
REQ-015 On RD_HI completion SHALL enter FIN: done=1, error=0, busy=0 for one cycle, then IDLE; start in FIN SHALL be ignored.
REQ-016 result SHALL hold its value between jobs and SHALL update only at read completions.
REQ-017 Latency against a responder that registers mem_ready one cycle after mem_valid: each transaction plus gap = 3 cycles; done high 3*(N+2)-1 edges after the start edge (14 for N=3).
REQ-018 mem_valid SHALL never be high in IDLE, GAP or FIN.

Reset
REQ-019 resetn=0 SHALL immediately (asynchronously) force IDLE, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, busy=0, done=0, error=0, result=0, k=0, timeout counter=0.
REQ-020 Reset mid-transaction SHALL abandon the job with no done pulse; first start after release SHALL begin a fresh job at k=0.
REQ-021 Leaving reset SHALL require one edge with resetn=1 before start is accepted.

Configuration
REQ-022 Macro ACCEL_INITIATOR_TIMEOUT_EN selects the watchdog.
REQ-023 Undefined: no counter; SHALL wait indefinitely for mem_ready; error SHALL be constant 0.
REQ-024 Defined: counter increments each cycle mem_valid=1 and mem_ready=0, clears at transaction completion; on reaching TIMEOUT SHALL drop mem_valid next cycle, enter FIN with done=1, error=1, result unchanged.

Verification
REQ-025 N=3, operands {3,5,7}, one-wait responder -> writes to 'h1003000/'h1003004/'h1003008 with data 3,5,7, reads 'h1004000/'h1004004, result=105, done at edge 14, error=0.
REQ-026 Operands {'hFFFFFFFF,'hFFFFFFFF,1}, responder returns 'hFFFFFFFE00000001 -> result='hFFFFFFFE00000001, low word loaded first.
REQ-027 Responder stalls mem_ready 10 cycles on write k=1 -> addr/wdata/wstrb stable all 10 cycles, exactly one GAP cycle after ready, done 10 cycles later than REQ-025.
REQ-028 start held high through a job and pulsed in FIN -> exactly one job executed, second start accepted only in following IDLE cycle.
REQ-029 resetn low during RD_LO -> mem_valid=0 same cycle, no done; next job completes normally with correct result.
REQ-030 With ACCEL_INITIATOR_TIMEOUT_EN, TIMEOUT=255, responder never ready -> mem_valid drops after 255 wait cycles, done=1 error=1, result unchanged; without macro, mem_valid stays high, error=0.
